// File: rtl/rv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_mem_pkg
//  Description : Shared types and constants for the rv_cpu memory arbiter.
//                Response-owner encoding and the byte-to-word address split.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_mem_pkg;

    // Which requester owns the read data returning from the RAM this cycle
    typedef enum logic [1:0] {
        OWN_IDLE    = 2'd0,
        OWN_IM      = 2'd1,
        OWN_DM_LOAD = 2'd2
    } owner_t;

    // Byte address bit where the 32-bit word address begins
    localparam int c_word_lsb = 2;

endpackage : rv_mem_pkg
`default_nettype wire

// File: rtl/rv_mem_burst_limiter.sv
`default_nettype none
// ============================================================================
//  Module      : rv_mem_burst_limiter
//  Description : Counts consecutive data grants issued while a fetch is
//                waiting and flags when fetch must be given the next slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_mem_burst_limiter #(
    parameter int MAX_DM_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_im_req,
    input  logic i_grant_dm,
    input  logic i_grant_im,
    output logic o_starve
);

    localparam logic [3:0] c_max_burst = 4'(MAX_DM_BURST);

    logic [3:0] r_burst_cnt;

    // Count data grants that overtook a waiting fetch; saturate at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_burst_cnt <= 4'd0;
        end else if (i_grant_im || !i_im_req) begin
            r_burst_cnt <= 4'd0;
        end else if (i_grant_dm && (r_burst_cnt != c_max_burst)) begin
            r_burst_cnt <= r_burst_cnt + 4'd1;
        end
    end

    // Fetch has waited through a full data burst and must win the next slot
    always_comb begin
        o_starve = i_im_req && (r_burst_cnt == c_max_burst);
    end

endmodule : rv_mem_burst_limiter
`default_nettype wire

// File: rtl/rv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rv_mem_arbiter
//  Description : Shares one single-port synchronous RAM between the rv_cpu
//                fetch port and load/store port. Data has priority, a burst
//                limiter prevents fetch starvation, read data is steered back
//                to its requester one cycle after the grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_mem_arbiter #(
    parameter int ADDR_WIDTH   = 14,
    parameter int MAX_DM_BURST = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  im_req_i,
    input  logic [31:0]           im_addr_i,
    output logic [31:0]           im_data_o,
    output logic                  im_valid_o,
    input  logic                  dm_load_i,
    input  logic                  dm_store_i,
    input  logic [31:0]           dm_addr_i,
    input  logic [31:0]           dm_data_s_i,
    input  logic [3:0]            dm_data_select_i,
    output logic                  dm_ack_o,
    output logic [31:0]           dm_data_l_o,
    output logic                  dm_valid_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic [3:0]            mem_wmask_o,
    output logic                  mem_we_o,
    input  logic [31:0]           mem_rdata_i
);

    import rv_mem_pkg::*;

    logic                  w_starve;
    logic                  w_grant_dm;
    logic                  w_grant_im;
    logic                  r_fetch_inflight;
    owner_t                r_owner;
    owner_t                w_owner_next;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic [ADDR_WIDTH-1:0] w_dm_word;
    logic [ADDR_WIDTH-1:0] w_im_word;
    logic                  w_unused_addr_bits;

    // Byte offset and bits above the RAM depth are dropped (addresses alias)
    assign w_dm_word = dm_addr_i[ADDR_WIDTH+c_word_lsb-1:c_word_lsb];
    assign w_im_word = im_addr_i[ADDR_WIDTH+c_word_lsb-1:c_word_lsb];
    assign w_unused_addr_bits = ^{im_addr_i[31:ADDR_WIDTH+c_word_lsb],
                                  im_addr_i[c_word_lsb-1:0],
                                  dm_addr_i[31:ADDR_WIDTH+c_word_lsb],
                                  dm_addr_i[c_word_lsb-1:0]};

    rv_mem_burst_limiter #(
        .MAX_DM_BURST (MAX_DM_BURST)
    ) u_burst_limiter (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_im_req   (im_req_i),
        .i_grant_dm (w_grant_dm),
        .i_grant_im (w_grant_im),
        .o_starve   (w_starve)
    );

    // Grant decision: data first unless fetch is owed a slot; nothing in reset
    always_comb begin
        w_grant_dm = !rst_i && (dm_load_i || dm_store_i)
                     && !(w_starve && !r_fetch_inflight);
        w_grant_im = !rst_i && im_req_i && !w_grant_dm && !r_fetch_inflight;
    end

    // Owner register: remembers who the RAM read issued this cycle belongs to
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_owner <= OWN_IDLE;
        end else begin
            r_owner <= w_owner_next;
        end
    end

    // Next owner; a granted data access that is not a store is a load
    always_comb begin
        w_owner_next = OWN_IDLE;
        if (w_grant_dm && !dm_store_i) begin
            w_owner_next = OWN_DM_LOAD;
        end else if (w_grant_im) begin
            w_owner_next = OWN_IM;
        end
    end

    // Block a second fetch of the still-held address until its data returns
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_inflight <= 1'b0;
        end else if (w_grant_im) begin
            r_fetch_inflight <= 1'b1;
        end else if (r_owner == OWN_IM) begin
            r_fetch_inflight <= 1'b0;
        end
    end

    // Hold the last granted word address so the RAM address is stable when idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_addr <= '0;
        end else if (w_grant_dm) begin
            r_last_addr <= w_dm_word;
        end else if (w_grant_im) begin
            r_last_addr <= w_im_word;
        end
    end

    // RAM-side and requester-side outputs; valids are suppressed during reset
    always_comb begin
        mem_addr_o  = r_last_addr;
        mem_we_o    = 1'b0;
        mem_wmask_o = 4'b0000;
        mem_wdata_o = 32'd0;
        if (w_grant_dm) begin
            mem_addr_o = w_dm_word;
            if (dm_store_i) begin
                mem_we_o    = 1'b1;
                mem_wmask_o = dm_data_select_i;
                mem_wdata_o = dm_data_s_i;
            end
        end else if (w_grant_im) begin
            mem_addr_o = w_im_word;
        end
        dm_ack_o    = w_grant_dm;
        im_valid_o  = !rst_i && (r_owner == OWN_IM);
        dm_valid_o  = !rst_i && (r_owner == OWN_DM_LOAD);
        im_data_o   = mem_rdata_i;
        dm_data_l_o = mem_rdata_i;
    end

endmodule : rv_mem_arbiter
`default_nettype wire

// File: tb/tb_rv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_mem_arbiter
//  Description : Self-checking bench for rv_mem_arbiter with a behavioural
//                RAM and a cycle-level reference model of the grant rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_mem_arbiter;

    localparam int AW   = 14;
    localparam int MAXB = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          im_req_i = 1'b0;
    logic [31:0]   im_addr_i = 32'd0;
    logic [31:0]   im_data_o;
    logic          im_valid_o;
    logic          dm_load_i = 1'b0;
    logic          dm_store_i = 1'b0;
    logic [31:0]   dm_addr_i = 32'd0;
    logic [31:0]   dm_data_s_i = 32'd0;
    logic [3:0]    dm_data_select_i = 4'd0;
    logic          dm_ack_o;
    logic [31:0]   dm_data_l_o;
    logic          dm_valid_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [3:0]    mem_wmask_o;
    logic          mem_we_o;
    logic [31:0]   mem_rdata_i;

    int n_pass  = 0;
    int n_total = 0;

    rv_mem_arbiter #(
        .ADDR_WIDTH   (AW),
        .MAX_DM_BURST (MAXB)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .im_req_i         (im_req_i),
        .im_addr_i        (im_addr_i),
        .im_data_o        (im_data_o),
        .im_valid_o       (im_valid_o),
        .dm_load_i        (dm_load_i),
        .dm_store_i       (dm_store_i),
        .dm_addr_i        (dm_addr_i),
        .dm_data_s_i      (dm_data_s_i),
        .dm_data_select_i (dm_data_select_i),
        .dm_ack_o         (dm_ack_o),
        .dm_data_l_o      (dm_data_l_o),
        .dm_valid_o       (dm_valid_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_wmask_o      (mem_wmask_o),
        .mem_we_o         (mem_we_o),
        .mem_rdata_i      (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural single-port synchronous RAM with a bench-side preload port
    logic [31:0]   ram [0:(1<<AW)-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [31:0]   pl_data = 32'd0;

    always @(posedge clk_i) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
        mem_rdata_i <= ram[mem_addr_o];
    end

    task automatic preload(input int a, input logic [31:0] d);
        @(negedge clk_i);
        pl_en = 1'b1; pl_addr = AW'(a); pl_data = d;
        @(posedge clk_i);
        #1 pl_en = 1'b0;
    endtask

    task automatic drive_idle();
        im_req_i = 1'b0; dm_load_i = 1'b0; dm_store_i = 1'b0;
        dm_data_select_i = 4'd0; dm_data_s_i = 32'd0;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_i = 1'b1; im_req_i = 1'b1; im_addr_i = 32'h0; dm_load_i = 1'b1; dm_addr_i = 32'h8;
        @(negedge clk_i); #1;
        n_total++;
        if ({dm_ack_o, mem_we_o, mem_wmask_o, im_valid_o, dm_valid_o} !== 8'h00)
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {dm_ack_o, mem_we_o, mem_wmask_o, im_valid_o, dm_valid_o});
        else n_pass++;
        @(negedge clk_i);
        rst_i = 1'b0; #1;
        n_total++;
        if ({dm_ack_o, mem_addr_o} !== {1'b1, 14'h0002})
            $display("FAIL reset_first_grant: got ack=%b addr=%h expected ack=1 addr=0002", dm_ack_o, mem_addr_o);
        else n_pass++;
        @(negedge clk_i);
        drive_idle(); #1;
        n_total++;
        if ({dm_valid_o, im_valid_o} !== 2'b10)
            $display("FAIL reset_first_valid: got dm/im=%b expected 10", {dm_valid_o, im_valid_o});
        else n_pass++;
    endtask

    task automatic test_fetch();
        preload(32'h40, 32'h00500093);
        @(negedge clk_i);
        im_req_i = 1'b1; im_addr_i = 32'h100; #1;
        n_total++;
        if ({mem_addr_o, dm_ack_o, mem_we_o} !== {14'h0040, 2'b00})
            $display("FAIL fetch_addr: got addr=%h ack=%b we=%b expected 0040/0/0", mem_addr_o, dm_ack_o, mem_we_o);
        else n_pass++;
        @(negedge clk_i); #1;
        n_total++;
        if ({im_valid_o, im_data_o} !== {1'b1, 32'h00500093})
            $display("FAIL fetch_data: got v=%b d=%h expected 1/00500093", im_valid_o, im_data_o);
        else n_pass++;
        @(negedge clk_i); #1;
        n_total++;
        if (im_valid_o !== 1'b0)
            $display("FAIL fetch_no_refetch: got im_valid=%b expected 0", im_valid_o);
        else n_pass++;
        drive_idle();
        @(negedge clk_i);
    endtask

    task automatic test_store_load();
        preload(32'h80, 32'h11223344);
        @(negedge clk_i);
        dm_store_i = 1'b1; dm_addr_i = 32'h200; dm_data_s_i = 32'hDEADBEEF; dm_data_select_i = 4'b0011; #1;
        n_total++;
        if ({dm_ack_o, mem_we_o, mem_wmask_o, mem_addr_o, mem_wdata_o} !== {2'b11, 4'b0011, 14'h0080, 32'hDEADBEEF})
            $display("FAIL store_grant: got ack=%b we=%b mask=%b addr=%h wd=%h expected 1/1/0011/0080/deadbeef",
                     dm_ack_o, mem_we_o, mem_wmask_o, mem_addr_o, mem_wdata_o);
        else n_pass++;
        @(negedge clk_i);
        dm_store_i = 1'b0; dm_load_i = 1'b1; dm_data_select_i = 4'b0000; #1;
        n_total++;
        if ({dm_ack_o, mem_we_o, mem_wmask_o, mem_addr_o, dm_valid_o} !== {2'b10, 4'b0000, 14'h0080, 1'b0})
            $display("FAIL load_grant: got ack=%b we=%b mask=%b addr=%h dv=%b expected 1/0/0000/0080/0",
                     dm_ack_o, mem_we_o, mem_wmask_o, mem_addr_o, dm_valid_o);
        else n_pass++;
        @(negedge clk_i);
        drive_idle(); #1;
        n_total++;
        if ({dm_valid_o, dm_data_l_o} !== {1'b1, 32'h1122BEEF})
            $display("FAIL load_data: got v=%b d=%h expected 1/1122beef", dm_valid_o, dm_data_l_o);
        else n_pass++;
    endtask

    task automatic test_contention();
        preload(32'hC0, 32'hA5A50001);
        preload(32'hC1, 32'h5A5A0002);
        @(negedge clk_i);
        im_req_i = 1'b1; im_addr_i = 32'h300; dm_load_i = 1'b1; dm_addr_i = 32'h304; #1;
        n_total++;
        if ({dm_ack_o, mem_addr_o} !== {1'b1, 14'h00C1})
            $display("FAIL contend_dm_first: got ack=%b addr=%h expected 1/00c1", dm_ack_o, mem_addr_o);
        else n_pass++;
        @(negedge clk_i);
        dm_load_i = 1'b0; #1;
        n_total++;
        if ({dm_ack_o, mem_addr_o, dm_valid_o, dm_data_l_o, im_valid_o} !== {1'b0, 14'h00C0, 1'b1, 32'h5A5A0002, 1'b0})
            $display("FAIL contend_fetch_grant: got ack=%b addr=%h dv=%b dd=%h iv=%b expected 0/00c0/1/5a5a0002/0",
                     dm_ack_o, mem_addr_o, dm_valid_o, dm_data_l_o, im_valid_o);
        else n_pass++;
        @(negedge clk_i); #1;
        n_total++;
        if ({im_valid_o, im_data_o} !== {1'b1, 32'hA5A50001})
            $display("FAIL contend_fetch_data: got v=%b d=%h expected 1/a5a50001", im_valid_o, im_data_o);
        else n_pass++;
        drive_idle();
        @(negedge clk_i);
    endtask

    task automatic test_starvation();
        logic [11:0] acks, ivs, fgr;
        int          done;
        done = 0; acks = '0; ivs = '0; fgr = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            im_req_i = 1'b1; im_addr_i = 32'h400;
            dm_load_i = (done < 10); dm_addr_i = 32'h800; #1;
            acks[11-i] = dm_ack_o;
            ivs[11-i]  = im_valid_o;
            fgr[11-i]  = !dm_ack_o && (mem_addr_o === 14'h0100);
            if (dm_ack_o) done++;
        end
        n_total++;
        if (acks !== 12'b111101111011)
            $display("FAIL starve_acks: got %b expected 111101111011", acks);
        else n_pass++;
        n_total++;
        if (fgr !== 12'b000010000100)
            $display("FAIL starve_fetch_grants: got %b expected 000010000100", fgr);
        else n_pass++;
        n_total++;
        if (ivs !== 12'b000001000010)
            $display("FAIL starve_fetch_valids: got %b expected 000001000010", ivs);
        else n_pass++;
        @(negedge clk_i);
        drive_idle();
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk_i);
        dm_load_i = 1'b1; dm_addr_i = 32'h40; #1;
        n_total++;
        if (dm_ack_o !== 1'b1)
            $display("FAIL midrd_grant: got ack=%b expected 1", dm_ack_o);
        else n_pass++;
        @(negedge clk_i);
        rst_i = 1'b1; dm_load_i = 1'b0; im_req_i = 1'b1; im_addr_i = 32'h44; #1;
        n_total++;
        if ({dm_ack_o, mem_we_o, mem_wmask_o, im_valid_o, dm_valid_o} !== 8'h00)
            $display("FAIL midrd_in_reset: got %b expected 00000000",
                     {dm_ack_o, mem_we_o, mem_wmask_o, im_valid_o, dm_valid_o});
        else n_pass++;
        @(negedge clk_i);
        rst_i = 1'b0; #1;
        n_total++;
        if ({dm_valid_o, im_valid_o, dm_ack_o, mem_addr_o} !== {3'b000, 14'h0011})
            $display("FAIL midrd_after_reset: got dv=%b iv=%b ack=%b addr=%h expected 0/0/0/0011",
                     dm_valid_o, im_valid_o, dm_ack_o, mem_addr_o);
        else n_pass++;
        @(negedge clk_i); #1;
        n_total++;
        if ({im_valid_o, dm_valid_o} !== 2'b10)
            $display("FAIL midrd_fetch_valid: got iv/dv=%b expected 10", {im_valid_o, dm_valid_o});
        else n_pass++;
        drive_idle();
        @(negedge clk_i);
    endtask

    task automatic test_alias();
        preload(1, 32'hCAFE0001);
        @(negedge clk_i);
        dm_load_i = 1'b1; dm_addr_i = 32'h00010004; #1;
        n_total++;
        if ({dm_ack_o, mem_addr_o} !== {1'b1, 14'h0001})
            $display("FAIL alias_addr: got ack=%b addr=%h expected 1/0001", dm_ack_o, mem_addr_o);
        else n_pass++;
        @(negedge clk_i);
        drive_idle(); #1;
        n_total++;
        if ({dm_valid_o, dm_data_l_o} !== {1'b1, 32'hCAFE0001})
            $display("FAIL alias_data: got v=%b d=%h expected 1/cafe0001", dm_valid_o, dm_data_l_o);
        else n_pass++;
    endtask

    // Random traffic against a model of the arbitration rules and RAM contents
    task automatic test_random();
        logic [31:0] mm [0:63];
        int          cnt, pend, w_im, w_dm, k, errs;
        bit          infl, starve_now, gdm, gim, exp_we;
        logic [3:0]  exp_mask;
        logic [31:0] pdata;
        for (int i = 0; i < 64; i++) begin
            mm[i] = $urandom;
            preload(i, mm[i]);
        end
        @(negedge clk_i);
        drive_idle(); rst_i = 1'b1;
        cnt = 0; pend = 0; infl = 1'b0; pdata = 32'd0; errs = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk_i);
            rst_i = 1'b0;
            w_im = $urandom_range(0, 63);
            w_dm = $urandom_range(0, 63);
            im_req_i  = ($urandom_range(0, 3) != 0);
            im_addr_i = ($urandom & 32'hFFFF0000) | (32'(w_im) << 2) | ($urandom & 32'h3);
            k = $urandom_range(0, 3);
            dm_load_i  = (k == 1) || (k == 2);
            dm_store_i = (k == 3);
            dm_addr_i  = ($urandom & 32'hFFFF0000) | (32'(w_dm) << 2) | ($urandom & 32'h3);
            dm_data_s_i = $urandom;
            dm_data_select_i = 4'($urandom);
            #1;
            starve_now = im_req_i && (cnt == MAXB) && !infl;
            gdm = (dm_load_i || dm_store_i) && !starve_now;
            gim = im_req_i && !gdm && !infl;
            exp_we = gdm && dm_store_i;
            exp_mask = exp_we ? dm_data_select_i : 4'b0000;
            n_total++;
            if ({dm_ack_o, mem_we_o, mem_wmask_o, im_valid_o, dm_valid_o} !==
                {gdm, exp_we, exp_mask, pend == 1, pend == 2}) begin
                if (errs < 10)
                    $display("FAIL rand_ctrl c=%0d: got %b expected %b", c,
                             {dm_ack_o, mem_we_o, mem_wmask_o, im_valid_o, dm_valid_o},
                             {gdm, exp_we, exp_mask, pend == 1, pend == 2});
                errs++;
            end else n_pass++;
            if (gdm || gim) begin
                n_total++;
                if (mem_addr_o !== AW'(gdm ? w_dm : w_im)) begin
                    if (errs < 10)
                        $display("FAIL rand_addr c=%0d: got %h expected %h", c, mem_addr_o, AW'(gdm ? w_dm : w_im));
                    errs++;
                end else n_pass++;
            end
            if (exp_we) begin
                n_total++;
                if (mem_wdata_o !== dm_data_s_i) begin
                    if (errs < 10)
                        $display("FAIL rand_wdata c=%0d: got %h expected %h", c, mem_wdata_o, dm_data_s_i);
                    errs++;
                end else n_pass++;
            end
            if (pend != 0) begin
                n_total++;
                if ((pend == 1 ? im_data_o : dm_data_l_o) !== pdata) begin
                    if (errs < 10)
                        $display("FAIL rand_rdata c=%0d: got %h expected %h", c,
                                 (pend == 1 ? im_data_o : dm_data_l_o), pdata);
                    errs++;
                end else n_pass++;
            end
            @(posedge clk_i);
            if (gdm && !dm_store_i) begin
                pend = 2; pdata = mm[w_dm];
            end else if (gim) begin
                pend = 1; pdata = mm[w_im];
            end else begin
                pend = 0;
            end
            if (exp_we)
                for (int b = 0; b < 4; b++)
                    if (exp_mask[b]) mm[w_dm][8*b +: 8] = dm_data_s_i[8*b +: 8];
            if (gim || !im_req_i) cnt = 0;
            else if (gdm && cnt < MAXB) cnt++;
            infl = gim;
        end
        @(negedge clk_i);
        drive_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        drive_idle();
        @(posedge clk_i);
        test_reset();
        test_fetch();
        test_store_load();
        test_contention();
        test_starvation();
        test_reset_mid_read();
        test_alias();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_rv_mem_arbiter
`default_nettype wire

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
Shares one single-port synchronous RAM between the rv_cpu instruction-fetch port and its load/store port.
- Grants at most one access per cycle.
- Data accesses have priority. A burst limiter keeps fetch from starving.
- Read data returns with a fixed one-cycle latency and is steered back to the requester that issued it.
- Sits between rv_cpu and the system RAM, replacing direct dual-port memory hookup.

Parameters:
ADDR_WIDTH, 14, RAM word-address width (RAM depth = 2**ADDR_WIDTH words of 32 bits)
MAX_DM_BURST, 4, maximum consecutive data grants while a fetch is pending (range 1..15)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
im_req_i  in  1  fetch request (level); im_addr_i held stable until im_valid_o
im_addr_i  in  32  fetch byte address
im_data_o  out  32  fetched instruction
im_valid_o  out  1  im_data_o valid; one-cycle pulse per granted fetch
dm_load_i  in  1  load request (level, held until dm_ack_o)
dm_store_i  in  1  store request (level, held until dm_ack_o); mutually exclusive with dm_load_i
dm_addr_i  in  32  data byte address
dm_data_s_i  in  32  store data
dm_data_select_i  in  4  store byte enables
dm_ack_o  out  1  combinational; high in the cycle the data request is granted
dm_data_l_o  out  32  load data
dm_valid_o  out  1  load data valid; pulse one cycle after load grant
mem_addr_o  out  ADDR_WIDTH  RAM word address = granted byte address bits [ADDR_WIDTH+1:2]
mem_wdata_o  out  32  RAM write data
mem_wmask_o  out  4  RAM byte write mask (0000 unless storing)
mem_we_o  out  1  RAM write strobe
mem_rdata_i  in  32  RAM read data, valid one cycle after the address is presented

Behaviour:
- Grant decision (combinational, each cycle):
  - grant_dm = (dm_load_i | dm_store_i) & ~(im_req_i & burst_cnt == MAX_DM_BURST & ~fetch_inflight)
  - grant_im = im_req_i & ~grant_dm & ~fetch_inflight
- fetch_inflight: registered, set the cycle after grant_im, clears with im_valid_o. Prevents a duplicate fetch of the same held address.
- On grant_dm:
  - mem_addr_o from dm_addr_i; dm_ack_o = 1.
  - Store: mem_we_o = 1, mem_wmask_o = dm_data_select_i, mem_wdata_o = dm_data_s_i. No dm_valid_o.
  - Load: mem_we_o = 0; dm_valid_o = 1 next cycle with dm_data_l_o = mem_rdata_i.
- On grant_im: mem_addr_o from im_addr_i; im_valid_o = 1 next cycle with im_data_o = mem_rdata_i.
- No grant: mem_we_o = 0, mem_wmask_o = 0, mem_addr_o holds its last value (don't-care).
- Response routing: 2-bit owner register {IDLE, IM, DM_LOAD}, written every cycle from the grant.
  - im_valid_o = (owner == IM); dm_valid_o = (owner == DM_LOAD).
  - im_data_o and dm_data_l_o both carry mem_rdata_i and are qualified by their valid.
- burst_cnt (4 bits):
  - Increments on grant_dm while im_req_i is high and saturates at MAX_DM_BURST.
  - Resets to 0 on grant_im or when im_req_i is low.
  - When it reaches MAX_DM_BURST, the next free cycle goes to fetch.
- Throughput: one access per cycle. Back-to-back loads give one dm_valid_o per cycle.
- Simultaneous load and store requests: protocol violation; store wins (dm_store_i decoded first).
- Address bits [1:0] are ignored; bits above ADDR_WIDTH+1 are ignored (address aliasing).
- Reset: owner = IDLE, burst_cnt = 0, fetch_inflight = 0.
  - im_valid_o, dm_valid_o, dm_ack_o, mem_we_o = 0; mem_wmask_o = 0.
  - Any read in flight at reset is discarded: no valid is produced after reset deasserts.
- Requests asserted during reset are not granted until the first cycle with rst_i low.

Decomposition:
- Shared package rv_mem_pkg: owner enum (OWN_IDLE, OWN_IM, OWN_DM_LOAD) and the byte-to-word address slicing constant.
- One natural sub-module: rv_mem_burst_limiter, holding burst_cnt and the starvation-override output.
- Grant logic and owner register stay in the top-level module.

Test Plan:
1. Fetch only: im_req_i = 1, im_addr_i = 0x100, RAM[0x40] = 0x00500093 -> mem_addr_o = 0x40 in cycle 0; im_valid_o = 1 with im_data_o = 0x00500093 in cycle 1; no second grant while the address is held.
2. Store then load: store to 0x200 with data 0xDEADBEEF, select 0b0011; then load 0x200 with RAM preset to 0x11223344 -> dm_ack_o on each grant; mem_wmask_o = 0011; load returns 0x1122BEEF with dm_valid_o one cycle after its ack.
3. Contention: fetch and load requested together -> dm_ack_o this cycle; fetch granted the next cycle; im_valid_o one cycle after that.
4. Starvation: MAX_DM_BURST = 4, im_req_i held high, 10 back-to-back loads -> exactly 4 data grants, 1 fetch grant, 4 data grants, 1 fetch grant; burst_cnt never exceeds 4.
5. Reset mid-read: load granted, then rst_i = 1 in the next cycle -> dm_valid_o stays 0; all outputs at reset values; first grant occurs in the cycle after rst_i falls.
6. Address aliasing: load from 0x00010004 with ADDR_WIDTH = 14 -> mem_addr_o = 0x0001.
